// File: rtl/grey_blur_3x3.sv
// Streaming 3x3 Gaussian blur (1-2-1 separable kernel) on an 8-bit grey raster stream.
// Two line buffers feed a 3x3 window. Each interior window position yields one
// rounded blurred pixel on a vld/busy output channel with a single output register.
module grey_blur_3x3 #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_grey_vld,
    input  logic [23:0] i_grey_data,
    output logic        i_grey_busy,
    input  logic        o_blur_busy,
    output logic        o_blur_vld,
    output logic [23:0] o_blur_data
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Raster position of the next input pixel
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    // Line buffers: lb0 holds the previous row, lb1 the row before that
    logic [7:0] lb0_q [IMG_W];
    logic [7:0] lb1_q [IMG_W];

    // 3x3 window [row top..bottom][col left..right] and its post-shift value
    logic [7:0] win_q [3][3];
    logic [7:0] win_d [3][3];

    logic        o_blur_vld_q;
    logic [23:0] o_blur_data_q;

    logic        acc;
    logic        emit;
    logic [7:0]  pix;
    logic [11:0] sum;
    logic [11:0] sum_rnd;
    logic [7:0]  y;

    // Only the low byte carries the grey value; the upper copies are ignored
    logic unused_grey_hi;
    assign unused_grey_hi = ^i_grey_data[23:8];

    assign pix         = i_grey_data[7:0];
    // A full output register that is stalled blocks every input, emitting or not
    assign i_grey_busy = o_blur_vld_q & o_blur_busy;
    assign acc         = i_grey_vld & ~i_grey_busy;
    assign emit        = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));

    assign o_blur_vld  = o_blur_vld_q;
    assign o_blur_data = o_blur_data_q;

    function automatic logic [11:0] ext(input logic [7:0] v);
        return {4'd0, v};
    endfunction

    // Window after the left shift, with the new right column from the buffers and input
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb1_q[col_q];
        win_d[1][2] = lb0_q[col_q];
        win_d[2][2] = pix;
    end

    // Weighted 1-2-1 x 1-2-1 sum (max 16*255 = 4080) and round-to-nearest divide by 16
    always_comb begin
        sum = ext(win_d[0][0])        + (ext(win_d[0][1]) << 1) + ext(win_d[0][2])
            + (ext(win_d[1][0]) << 1) + (ext(win_d[1][1]) << 2) + (ext(win_d[1][2]) << 1)
            + ext(win_d[2][0])        + (ext(win_d[2][1]) << 1) + ext(win_d[2][2]);
        sum_rnd = sum + 12'd8;
        y       = sum_rnd[11:4];
    end

    // Line buffers and window advance on every accepted pixel
    always_ff @(posedge i_clk) begin
        // NOTE: line buffers and window are not reset; stale contents never reach the output because emit excludes them.
        if (acc) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pix;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

    // Column/row counters wrapping at row end and frame end
    always_ff @(posedge i_clk or negedge i_rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!i_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (acc) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Output register: load on emit, otherwise drain when the word is taken
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_blur_vld_q  <= 1'b0;
            o_blur_data_q <= '0;
        end else if (emit) begin
            o_blur_vld_q  <= 1'b1;
            o_blur_data_q <= {y, y, y};
        end else if (o_blur_vld_q && !o_blur_busy) begin
            o_blur_vld_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_grey_blur_3x3.sv
// Self-checking bench for grey_blur_3x3 on an 8x6 image: directed frame table,
// random frames against a convolution reference model, back-to-back frames and
// an asynchronous reset in the middle of a frame.
module tb_grey_blur_3x3;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_grey_vld;
    logic [23:0] i_grey_data;
    logic        i_grey_busy;
    logic        o_blur_busy;
    logic        o_blur_vld;
    logic [23:0] o_blur_data;

    grey_blur_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_grey_vld (i_grey_vld),
        .i_grey_data(i_grey_data),
        .i_grey_busy(i_grey_busy),
        .o_blur_busy(o_blur_busy),
        .o_blur_vld (o_blur_vld),
        .o_blur_data(o_blur_data)
    );

    always #5 i_clk = ~i_clk;

    typedef enum int { K_CONST = 0, K_IMPULSE = 1, K_RAMP = 2, K_RANDOM = 3 } kind_e;

    typedef struct {
        string name;
        kind_e kind;
        int    busy_pct;
        int    gap_pct;
        int    exp_outputs;
    } frame_vec_t;

    int          total = 0;
    int          bad   = 0;
    int          img [H][W];
    int          exp_q [$];
    int          out_cnt;
    bit          emit_prev;
    bit          stall_prev;
    bit          busy_prev;
    logic [23:0] data_prev;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
        end
    endtask

    // Reference: 1-2-1 separable kernel over the 3x3 neighbourhood, rounded /16
    function automatic int blur_ref(input int r, input int c);
        int k [3] = '{1, 2, 1};
        int s = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                s += k[dr] * k[dc] * img[r - 1 + dr][c - 1 + dc];
        return (s + 8) / 16;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Hand-derived results for the directed patterns; the model covers random frames
    function automatic int expect_at(input kind_e kind, input int r, input int c);
        int dr = iabs(r - 2);
        int dc = iabs(c - 2);
        case (kind)
            K_CONST:   return 100;
            K_IMPULSE: begin
                if (dr == 0 && dc == 0)      return 64;
                else if (dr + dc == 1)       return 32;
                else if (dr == 1 && dc == 1) return 16;
                else                         return 0;
            end
            K_RAMP:    return 10 * c;
            default:   return blur_ref(r, c);
        endcase
    endfunction

    task automatic fill_frame(input kind_e kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    K_CONST:   img[r][c] = 100;
                    K_IMPULSE: img[r][c] = (r == 2 && c == 2) ? 255 : 0;
                    K_RAMP:    img[r][c] = 10 * c;
                    default:   img[r][c] = int'($urandom_range(255));
                endcase
    endtask

    task automatic push_expected(input kind_e kind);
        for (int r = 1; r <= H - 2; r++)
            for (int c = 1; c <= W - 2; c++)
                exp_q.push_back(expect_at(kind, r, c));
    endtask

    // Sampled 1 time unit after the negedge drive, well away from the rising edge
    task automatic observe();
        int e;
        if (stall_prev) begin
            check("hold_vld", o_blur_vld, 1);
            check("hold_data", o_blur_data, data_prev);
        end
        if (!busy_prev) check("latency_vld", o_blur_vld, emit_prev);
        check("grey_busy", i_grey_busy, o_blur_vld & o_blur_busy);
        if (o_blur_vld && !o_blur_busy) begin
            out_cnt++;
            check("output_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", o_blur_data, {3{8'(e)}});
            end
        end
        busy_prev  = o_blur_busy;
        stall_prev = o_blur_vld & o_blur_busy;
        data_prev  = o_blur_data;
    endtask

    // Stream n pixels of img from position (0,0); upstream holds vld while stalled
    task automatic run_pixels(input int n, input int busy_pct, input int gap_pct);
        int sent = 0;
        int cyc  = 0;
        bit vld_hold = 0;
        bit acc;
        while (sent < n && cyc < 40 * n + 100) begin
            @(negedge i_clk);
            cyc++;
            o_blur_busy = (int'($urandom_range(99)) < busy_pct);
            i_grey_vld  = vld_hold || (int'($urandom_range(99)) >= gap_pct);
            i_grey_data = {3{8'(img[sent / W][sent % W])}};
            #1;
            observe();
            acc       = i_grey_vld && !i_grey_busy;
            emit_prev = acc && (sent / W) >= 2 && (sent % W) >= 2;
            vld_hold  = i_grey_vld && i_grey_busy;
            if (acc) sent++;
        end
        check("pixels_sent", sent, n);
    endtask

    task automatic drain();
        int cyc = 0;
        do begin
            @(negedge i_clk);
            i_grey_vld  = 1'b0;
            o_blur_busy = 1'b0;
            #1;
            observe();
            emit_prev = 1'b0;
            cyc++;
        end while ((o_blur_vld || exp_q.size() != 0) && cyc < 20);
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Assert reset mid-cycle, hold it with random inputs, release on a falling edge
    task automatic apply_reset(input int cycles);
        @(negedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        check("rst_async_vld", o_blur_vld, 0);
        check("rst_async_data", o_blur_data, 0);
        check("rst_async_busy", i_grey_busy, 0);
        repeat (cycles) begin
            @(negedge i_clk);
            i_grey_vld  = 1'($urandom_range(1));
            i_grey_data = 24'($urandom);
            o_blur_busy = 1'($urandom_range(1));
            #1;
            check("rst_hold_vld", o_blur_vld, 0);
            check("rst_hold_data", o_blur_data, 0);
            check("rst_hold_busy", i_grey_busy, 0);
        end
        @(negedge i_clk);
        i_rst       = 1'b1;
        i_grey_vld  = 1'b0;
        o_blur_busy = 1'b0;
        exp_q.delete();
        emit_prev  = 1'b0;
        stall_prev = 1'b0;
        busy_prev  = 1'b0;
    endtask

    frame_vec_t vecs [6];

    initial begin
        vecs[0] = '{"const100",      K_CONST,   0,  0,  NOUT};
        vecs[1] = '{"impulse",       K_IMPULSE, 0,  0,  NOUT};
        vecs[2] = '{"ramp",          K_RAMP,    0,  0,  NOUT};
        vecs[3] = '{"const_bp50",    K_CONST,   50, 0,  NOUT};
        vecs[4] = '{"random_bp_gap", K_RANDOM,  30, 20, NOUT};
        vecs[5] = '{"random_gap",    K_RANDOM,  0,  30, NOUT};

        i_rst       = 1'b1;
        i_grey_vld  = 1'b0;
        i_grey_data = '0;
        o_blur_busy = 1'b0;
        emit_prev   = 1'b0;
        stall_prev  = 1'b0;
        busy_prev   = 1'b0;
        data_prev   = '0;
        out_cnt     = 0;

        apply_reset(4);

        foreach (vecs[i]) begin
            fill_frame(vecs[i].kind);
            push_expected(vecs[i].kind);
            out_cnt = 0;
            run_pixels(NPIX, vecs[i].busy_pct, vecs[i].gap_pct);
            drain();
            check({vecs[i].name, "_count"}, out_cnt, vecs[i].exp_outputs);
        end

        // Two frames with no idle gap, then 3.5 rows of a third frame cut by reset
        out_cnt = 0;
        fill_frame(K_RANDOM);
        push_expected(K_RANDOM);
        run_pixels(NPIX, 0, 0);
        fill_frame(K_IMPULSE);
        push_expected(K_IMPULSE);
        run_pixels(NPIX, 20, 0);
        fill_frame(K_RAMP);
        push_expected(K_RAMP);
        run_pixels(3 * W + 4, 0, 0);
        // 48 outputs from two full frames plus row-2 centres (6) and centre (2,1)
        check("b2b_out_count", out_cnt, 2 * NOUT + 7);
        apply_reset(3);

        // Fresh frame after reset: exactly one frame of correct outputs, nothing stale
        out_cnt = 0;
        fill_frame(K_RANDOM);
        push_expected(K_RANDOM);
        run_pixels(NPIX, 30, 10);
        drain();
        check("post_reset_count", out_cnt, NOUT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grey_blur_3x3.md
# grey_blur_3x3

Streaming 3x3 Gaussian blur stage directly downstream of the colour-to-grey transform. Consumes the raster-scan grey pixel stream through a busy/vld point-to-point channel and buffers the two previous rows in line buffers. Emits one blurred pixel per interior window position, (IMG_W-2)x(IMG_H-2) per frame, on a second busy/vld channel toward the next pipeline stage.

## Interface
- IMG_W, 256, pixels per row; minimum 3; also the line-buffer depth.
- IMG_H, 256, rows per frame; minimum 3.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- i_grey_vld  in  1  upstream pixel valid.
- i_grey_data  in  24  grey pixel replicated in R/G/B; only [7:0] is used.
- i_grey_busy  out  1  stall upstream; combinational = o_blur_vld & o_blur_busy.
- o_blur_busy  in  1  downstream stall.
- o_blur_vld  out  1  output pixel valid.
- o_blur_data  out  24  blurred 8-bit value replicated in [23:16], [15:8] and [7:0].

## Operation
- Transfer rule, both channels: a word moves on a rising edge where vld=1 and busy=0. The sender holds data stable while vld&busy.
- Input accept: acc = i_grey_vld & ~i_grey_busy.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next input pixel.
  - On acc, col increments; it wraps to 0 and increments row.
  - At (IMG_H-1, IMG_W-1), both wrap to 0. The next pixel starts a new frame with no idle gap.
- Line buffers, IMG_W x 8 each: lb0 holds row-1 and lb1 holds row-2. On acc at column c: lb1[c]<=lb0[c], lb0[c]<=p.
- Window w[3][3] (rows top..bottom, cols left..right). On acc:
  - Columns shift left.
  - The new right column is {lb1[c], lb0[c], p}.
- Emit condition: acc with row>=2 and col>=2. The output is centered at (row-1, col-1).
- Computation, combinational from the post-shift window:
  - sum = w00+2w01+w02 + 2w10+4w11+2w12 + w20+2w21+w22, 12 bits, max 4080.
  - y = (sum+8)>>4, 8 bits. No saturation is needed.
- Output register:
  - On an emit, o_blur_data<={y,y,y} and o_blur_vld<=1.
  - Otherwise, if o_blur_vld & ~o_blur_busy, o_blur_vld<=0.
  - The simultaneous drain-and-emit case loads the new word (vld stays 1).
- Stale data left in the window at the start of a row or frame is never emitted, because the emit condition excludes it. The line buffers are not reset.

## Timing
- Reset values:
  - o_blur_vld=0 and o_blur_data=0.
  - i_grey_busy=0 (follows o_blur_vld).
  - col=0 and row=0.
- Latency: an emitting input accepted at edge E makes o_blur_vld=1 in the cycle after E.
- Throughput: 1 pixel/cycle when o_blur_busy=0.
- Backpressure: while o_blur_vld & o_blur_busy, i_grey_busy=1 and no counter, window or line-buffer state changes. o_blur_data is held.
- Non-emitting inputs (row<2 or col<2) are still blocked while the output register is full and stalled. This keeps the rule uniform.
- Reset mid-operation:
  - Assertion immediately clears o_blur_vld, o_blur_data and the counters.
  - After release, the first accepted pixel is (0,0) of a new frame, and no partial-frame output is emitted.
- Upstream vld gaps: state holds. Output spacing follows input spacing.

## Test plan
- Reset: hold i_rst=0 with random inputs. Required: o_blur_vld=0, o_blur_data=0, i_grey_busy=0. Then release.
- Constant frame, IMG_W=8, IMG_H=6, all pixels 100, o_blur_busy=0. Required: exactly 24 outputs, each 0x646464, back-to-back at 1/cycle.
- Impulse, same size, zeros except 255 at (2,2). Outputs in raster order over centers (1..4, 1..6):
  - (2,2)=64.
  - (1,2), (2,1), (2,3), (3,2)=32.
  - (1,1), (1,3), (3,1), (3,3)=16.
  - All others 0.
- Ramp, pixel=10*col. Required: the output at center column c is 10*c for every row.
- Backpressure: constant-frame stimulus with o_blur_busy randomly toggled ~50%. Required:
  - same 24 values, none lost or duplicated;
  - o_blur_data stable while vld&busy;
  - i_grey_busy=1 exactly when vld&busy.
- Two back-to-back frames, then an async reset pulse mid-row of a third frame followed by a fresh frame. Required:
  - each complete frame yields exactly 24 correct outputs;
  - the interrupted frame produces no output after reset assertion.
